// File: rtl/chan_tx_bridge_if.sv
// chan_tx_bridge_if
//   Groups the upstream valid/ready port and the downstream four-phase
//   bundled-data channel of chan_tx_bridge, plus its status outputs.
//   master : the bridge itself (drives in_ready, ch_req, ch_data, count, busy)
//   slave  : the environment (drives in_data, in_valid, ch_ack)
//
//   in_data  / in_valid / in_ready : synchronous upstream word handshake
//   ch_req   / ch_data  / ch_ack   : four-phase request, bundled data, ack
//   count                          : FIFO occupancy 0..DEPTH
//   busy                           : words buffered or handshake in progress
`timescale 1ns/1ps
interface chan_tx_bridge_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ch_req;
    logic [WIDTH-1:0] ch_data;
    logic             ch_ack;
    logic [CW-1:0]    count;
    logic             busy;

    modport master (
        input  in_data, in_valid, ch_ack,
        output in_ready, ch_req, ch_data, count, busy
    );

    modport slave (
        output in_data, in_valid, ch_ack,
        input  in_ready, ch_req, ch_data, count, busy
    );
endinterface

// File: rtl/chan_tx_bridge.sv
// chan_tx_bridge
//   Clocked upstream source stage for the channel pipeline. Words accepted
//   over a valid/ready port are buffered in a DEPTH-entry FIFO and emitted
//   one at a time on a four-phase bundled-data req/ack channel. The
//   returning ack is asynchronous and passes through a SYNC_STAGES-deep
//   synchroniser; the handshake FSM only ever looks at the synchronised ack.
//
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high
//   bus   : chan_tx_bridge_if.master (upstream port, channel, count, busy)
`timescale 1ns/1ps
module chan_tx_bridge #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    chan_tx_bridge_if.master bus
);
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } state_t;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    state_t                 state_q, state_d;
    logic                   ch_req_q, ch_req_d;
    logic [WIDTH-1:0]       ch_data_q, ch_data_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   push;
    logic                   launch;
    logic                   in_ready;

    // No full-bypass: a full FIFO refuses a word even if a launch pops
    // on the same edge.
    assign in_ready = (count_q < DEPTH_C);
    assign push     = bus.in_valid & in_ready;
    assign ack_s    = sync_q[SYNC_STAGES-1];

    // Ack synchroniser; stage 0 samples the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ch_ack};
        end
    end

    // FIFO storage: write-only here, read by the launch path into ch_data_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, launch})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state. A launch needs ack_s low, so an ack that is still
    // high (or rises spuriously) in IDLE/REQ_LO holds off the next word.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if ((count_q != '0) && !ack_s) state_d = REQ_HI;
            end
            REQ_HI: begin
                if (ack_s) state_d = REQ_LO;
            end
            REQ_LO: begin
                if (!ack_s) state_d = (count_q != '0) ? REQ_HI : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: launch (pop + load + raise req) and req release.
    always_comb begin
        launch    = 1'b0;
        ch_req_d  = ch_req_q;
        ch_data_d = ch_data_q;
        unique case (state_q)
            IDLE, REQ_LO: begin
                if ((count_q != '0) && !ack_s) launch = 1'b1;
            end
            REQ_HI: begin
                if (ack_s) ch_req_d = 1'b0;
            end
            default: ;
        endcase
        if (launch) begin
            ch_req_d  = 1'b1;
            ch_data_d = mem_q[rd_ptr_q];
        end
    end

    // Datapath registers; ch_data only moves on a launch edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ch_req_q  <= 1'b0;
            ch_data_q <= '0;
        end else begin
            if (push)   wr_ptr_q <= wr_ptr_q + AW'(1);
            if (launch) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q   <= count_d;
            ch_req_q  <= ch_req_d;
            ch_data_q <= ch_data_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.ch_req   = ch_req_q;
    assign bus.ch_data  = ch_data_q;
    assign bus.count    = count_q;
    assign bus.busy     = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_chan_tx_bridge.sv
`timescale 1ns/1ps
module tb_chan_tx_bridge;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic clk;
    logic reset;

    chan_tx_bridge_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    chan_tx_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard: words accepted upstream, in order, not yet seen downstream.
    logic [7:0] exp_q [$];
    int         recv_total = 0;
    logic [7:0] last_word  = 8'h00;
    bit         auto_ack   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Downstream monitor: every req rise delivers one word.
    always @(posedge bus.ch_req) begin
        logic [7:0] w;
        #1;
        recv_total++;
        last_word = bus.ch_data;
        $display("RECV word=0x%02h total=%0d t=%0t", bus.ch_data, recv_total, $time);
        if (exp_q.size() == 0) begin
            check("unexpected_word", 32'd1, 32'd0);
        end else begin
            w = exp_q.pop_front();
            check("order", {24'd0, bus.ch_data}, {24'd0, w});
        end
    end

    // Bundled data must stay put while req is high.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.ch_req === 1'b1)
            check("ch_data_stable", {24'd0, bus.ch_data}, {24'd0, last_word});
    end

    // Auto-acking downstream with random 1..20 ns delays.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (auto_ack && bus.ch_req === 1'b1 && bus.ch_ack === 1'b0) begin
                int n;
                #($urandom_range(1, 20));
                bus.ch_ack = 1'b1;
                n = 0;
                while (bus.ch_req !== 1'b0 && n < 200) begin
                    @(posedge clk);
                    #2;
                    n++;
                end
                check("auto_req_release_bound", {31'd0, (n < 200)}, 32'd1);
                #($urandom_range(1, 20));
                bus.ch_ack = 1'b0;
            end
        end
    end

    // Offer one word (called at a negedge); returns at the negedge after it
    // is accepted, leaving in_valid high so calls chain back-to-back.
    task automatic push_word(input logic [7:0] w);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (bus.in_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("push_accept_bound", {31'd0, (n < 500)}, 32'd1);
        @(posedge clk);
        exp_q.push_back(w);
        $display("PUSH word=0x%02h t=%0t", w, $time);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && bus.busy === 1'b0 && bus.ch_ack === 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain_bound"}, {31'd0, (n < 3000)}, 32'd1);
        check({tag, "_count_empty"}, {29'd0, bus.count}, 32'd0);
        check({tag, "_req_low"}, {31'd0, bus.ch_req}, 32'd0);
    endtask

    initial begin
        int n;
        int base;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.ch_ack   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_req", {31'd0, bus.ch_req}, 32'd0);
        check("rst_data", {24'd0, bus.ch_data}, 32'd0);
        check("rst_count", {29'd0, bus.count}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;

        // Single word: push at edge 1, req after edge 2
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        @(posedge clk);
        exp_q.push_back(8'hA5);
        #1;
        check("single_count_after_push", {29'd0, bus.count}, 32'd1);
        check("single_no_bypass", {31'd0, bus.ch_req}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("single_req_high", {31'd0, bus.ch_req}, 32'd1);
        check("single_data", {24'd0, bus.ch_data}, 32'h0000_00A5);
        check("single_count_after_pop", {29'd0, bus.count}, 32'd0);
        #3;
        bus.ch_ack = 1'b1;
        n = 0;
        while (bus.ch_req === 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("single_req_drop_latency", {31'd0, (n <= SYNC + 1)}, 32'd1);
        check("single_req_dropped", {31'd0, bus.ch_req}, 32'd0);
        #3;
        bus.ch_ack = 1'b0;
        repeat (SYNC + 3) @(negedge clk);
        check("single_busy_done", {31'd0, bus.busy}, 32'd0);
        check("single_data_held", {24'd0, bus.ch_data}, 32'h0000_00A5);

        // Fill/full with downstream holding ack low
        for (int i = 1; i <= 5; i++) push_word(8'(i));
        check("full_count", {29'd0, bus.count}, 32'd4);
        check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("full_req", {31'd0, bus.ch_req}, 32'd1);
        bus.in_data = 8'h06;
        repeat (5) @(negedge clk);
        check("full_stall_count", {29'd0, bus.count}, 32'd4);
        check("full_stall_ready", {31'd0, bus.in_ready}, 32'd0);
        auto_ack = 1'b1;
        push_word(8'h06);
        bus.in_valid = 1'b0;
        drain("fill");

        // Ordering with wrap: 16 words, random gaps and ack delays
        base = recv_total;
        for (int i = 0; i < 16; i++) begin
            push_word(8'(i));
            if ($urandom_range(0, 1) == 1) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        drain("wrap");
        check("wrap_delivered", recv_total - base, 32'd16);

        // Simultaneous push and relaunch pop
        auto_ack = 1'b0;
        push_word(8'hA1);
        push_word(8'hB2);
        push_word(8'hC3);
        bus.in_valid = 1'b0;
        check("simul_count_before", {29'd0, bus.count}, 32'd2);
        bus.ch_ack = 1'b1;
        n = 0;
        while (bus.ch_req !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("simul_req_release_bound", {31'd0, (n < 50)}, 32'd1);
        bus.ch_ack = 1'b0;
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        check("simul_wait_req_low", {31'd0, bus.ch_req}, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hD4;
        @(posedge clk);
        exp_q.push_back(8'hD4);
        #1;
        check("simul_relaunch", {31'd0, bus.ch_req}, 32'd1);
        check("simul_count_same", {29'd0, bus.count}, 32'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        auto_ack = 1'b1;
        drain("simul");

        // Reset mid-operation in REQ_HI, count=3, ack high
        auto_ack = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'h11 * 8'(i + 1));
        bus.in_valid = 1'b0;
        check("midrst_count3", {29'd0, bus.count}, 32'd3);
        check("midrst_req_hi", {31'd0, bus.ch_req}, 32'd1);
        bus.ch_ack = 1'b1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_req", {31'd0, bus.ch_req}, 32'd0);
        check("midrst_count", {29'd0, bus.count}, 32'd0);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        push_word(8'h7E);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_hold_req", {31'd0, bus.ch_req}, 32'd0);
        check("midrst_hold_count", {29'd0, bus.count}, 32'd1);
        bus.ch_ack = 1'b0;
        repeat (SYNC) @(posedge clk);
        #1;
        check("midrst_still_low", {31'd0, bus.ch_req}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_launch", {31'd0, bus.ch_req}, 32'd1);
        auto_ack = 1'b1;
        @(negedge clk);
        drain("midrst");

        // Spurious ack in IDLE, then push while ack_s is high
        auto_ack = 1'b0;
        bus.ch_ack = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        check("spur_req_idle", {31'd0, bus.ch_req}, 32'd0);
        check("spur_busy_idle", {31'd0, bus.busy}, 32'd0);
        push_word(8'h33);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("spur_hold_req", {31'd0, bus.ch_req}, 32'd0);
        check("spur_hold_count", {29'd0, bus.count}, 32'd1);
        bus.ch_ack = 1'b0;
        repeat (SYNC) @(posedge clk);
        #1;
        check("spur_still_low", {31'd0, bus.ch_req}, 32'd0);
        @(posedge clk);
        #1;
        check("spur_launch", {31'd0, bus.ch_req}, 32'd1);
        auto_ack = 1'b1;
        @(negedge clk);
        drain("spur");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
